// File: rtl/color2bw_pkg.sv
// color2bw_pkg: shared constants, coefficient select codes and the round/saturate helper
// for the color2bw_stream greyscale pipeline.
package color2bw_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_KR     = 54;
    localparam int DEF_KG     = 183;
    localparam int DEF_KB     = 19;
    localparam int DEF_USER_W = 2;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } coef_sel_e;

    // Round half up by adding half an LSB before dropping the fraction, then clamp to full scale.
    function automatic logic [63:0] round_sat(input logic [63:0] sum, input int data_w, input int coef_w);
        logic [63:0] y;
        logic [63:0] y_max;
        y     = (sum + (64'd1 << (coef_w - 1))) >> coef_w;
        y_max = (64'd1 << data_w) - 64'd1;
        return (y > y_max) ? y_max : y;
    endfunction
endpackage

// File: rtl/color2bw_mac3.sv
// color2bw_mac3: weighted RGB sum, S1 registers three products and S2 registers their sum.
module color2bw_mac3 import color2bw_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W
) (
    input  logic                     clk,
    input  logic                     i_en1,
    input  logic                     i_en2,
    input  logic [DATA_W-1:0]        i_r,
    input  logic [DATA_W-1:0]        i_g,
    input  logic [DATA_W-1:0]        i_b,
    input  logic [COEF_W-1:0]        i_kr,
    input  logic [COEF_W-1:0]        i_kg,
    input  logic [COEF_W-1:0]        i_kb,
    output logic [DATA_W+COEF_W+1:0] o_sum
);
    localparam int PW = DATA_W + COEF_W;
    localparam int SW = PW + 2;

    logic [PW-1:0] r_pr;
    logic [PW-1:0] r_pg;
    logic [PW-1:0] r_pb;
    logic [SW-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (i_en1) begin
            r_pr <= PW'(i_r) * PW'(i_kr);
            r_pg <= PW'(i_g) * PW'(i_kg);
            r_pb <= PW'(i_b) * PW'(i_kb);
        end
        if (i_en2)
            r_sum <= SW'(r_pr) + SW'(r_pg) + SW'(r_pb);
    end

    assign o_sum = r_sum;
endmodule

// File: rtl/color2bw_stream.sv
// color2bw_stream: 3-stage valid/ready RGB-to-grey pipeline with rounding and saturation.
// Define COLOR2BW_PROG_COEF_EN to add runtime-writable coefficients via the cfg_* ports.
module color2bw_stream import color2bw_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int KR     = DEF_KR,
    parameter int KG     = DEF_KG,
    parameter int KB     = DEF_KB,
    parameter int USER_W = DEF_USER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic [USER_W-1:0] out_user
`ifdef COLOR2BW_PROG_COEF_EN
    ,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [COEF_W-1:0] cfg_data
`endif
);
    logic                     r_v1;
    logic                     r_v2;
    logic                     r_v3;
    logic [USER_W-1:0]        r_u1;
    logic [USER_W-1:0]        r_u2;
    logic [USER_W-1:0]        r_u3;
    logic [DATA_W-1:0]        r_y;
    logic                     w_en1;
    logic                     w_en2;
    logic                     w_en3;
    logic [COEF_W-1:0]        w_kr;
    logic [COEF_W-1:0]        w_kg;
    logic [COEF_W-1:0]        w_kb;
    logic [DATA_W+COEF_W+1:0] w_sum;

    // A stage may advance when it is empty or the stage after it is advancing.
    assign w_en3 = !r_v3 || out_ready;
    assign w_en2 = !r_v2 || w_en3;
    assign w_en1 = !r_v1 || w_en2;
    assign in_ready = w_en1;

`ifdef COLOR2BW_PROG_COEF_EN
    logic [COEF_W-1:0] r_kr;
    logic [COEF_W-1:0] r_kg;
    logic [COEF_W-1:0] r_kb;
    coef_sel_e         w_sel;

    assign w_sel = coef_sel_e'(cfg_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kr <= COEF_W'(KR);
            r_kg <= COEF_W'(KG);
            r_kb <= COEF_W'(KB);
        end else if (cfg_we) begin
            if (w_sel == SEL_R) r_kr <= cfg_data;
            if (w_sel == SEL_G) r_kg <= cfg_data;
            if (w_sel == SEL_B) r_kb <= cfg_data;
        end
    end

    assign w_kr = r_kr;
    assign w_kg = r_kg;
    assign w_kb = r_kb;
`else
    assign w_kr = COEF_W'(KR);
    assign w_kg = COEF_W'(KG);
    assign w_kb = COEF_W'(KB);
`endif

    color2bw_mac3 #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_mac3 (
        .clk   (clk),
        .i_en1 (w_en1 && in_valid),
        .i_en2 (w_en2 && r_v1),
        .i_r   (in_r),
        .i_g   (in_g),
        .i_b   (in_b),
        .i_kr  (w_kr),
        .i_kg  (w_kg),
        .i_kb  (w_kb),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_y  <= '0;
            r_u3 <= '0;
        end else begin
            if (w_en1) r_v1 <= in_valid;
            if (w_en2) r_v2 <= r_v1;
            if (w_en3) r_v3 <= r_v2;
            if (w_en1 && in_valid) r_u1 <= in_user;
            if (w_en2 && r_v1) r_u2 <= r_u1;
            if (w_en3 && r_v2) begin
                r_y  <= DATA_W'(round_sat(64'(w_sum), DATA_W, COEF_W));
                r_u3 <= r_u2;
            end
        end
    end

    assign out_valid = r_v3;
    assign out_y     = r_y;
    assign out_user  = r_u3;
endmodule

// File: tb/tb_color2bw_stream.sv
// tb_color2bw_stream: directed vector table plus backpressure, reset and coefficient sequences.
// Coefficient-write checks are built only when COLOR2BW_PROG_COEF_EN is defined.
module tb_color2bw_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r;
    logic [7:0] in_g;
    logic [7:0] in_b;
    logic [1:0] in_user;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic [1:0] out_user;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;

    always #5 clk = ~clk;

    color2bw_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .in_user   (in_user),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_user  (out_user)
`ifdef COLOR2BW_PROG_COEF_EN
        ,
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data)
`endif
    );

    typedef struct {
        int r;
        int g;
        int b;
        int u;
        int y;
    } vec_t;

    vec_t tv[8];
    vec_t bp[6];
    int   cyc = 0;
    int   got_y[$];
    int   got_u[$];
    int   got_c[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_acc = 0;
    int   a0;
    int   y_hold;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (out_valid && out_ready) begin
            got_y.push_back(int'(out_y));
            got_u.push_back(int'(out_user));
            got_c.push_back(cyc);
        end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_r     = 8'(v.r);
        in_g     = 8'(v.g);
        in_b     = 8'(v.b);
        in_user  = 2'(v.u);
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input string nm);
        for (int k = 0; k < 60 && got_y.size() < n; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk(nm, got_y.size(), n);
    endtask

    task automatic clear_q();
        got_y.delete();
        got_u.delete();
        got_c.delete();
    endtask

    task automatic cfg(input int sel, input int data);
        cfg_we   = 1'b1;
        cfg_sel  = 2'(sel);
        cfg_data = 8'(data);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        tv[0] = '{255, 255, 255, 0, 255};
        tv[1] = '{0, 0, 0, 1, 0};
        tv[2] = '{255, 0, 0, 2, 54};
        tv[3] = '{0, 255, 0, 3, 182};
        tv[4] = '{0, 0, 255, 0, 19};
        tv[5] = '{1, 1, 1, 1, 1};
        tv[6] = '{2, 0, 0, 2, 0};
        tv[7] = '{3, 0, 0, 3, 1};
        bp[0] = '{10, 10, 10, 1, 10};
        bp[1] = '{200, 200, 200, 2, 200};
        bp[2] = '{0, 100, 0, 3, 71};
        bp[3] = '{100, 0, 0, 0, 21};
        bp[4] = '{0, 0, 200, 1, 15};
        bp[5] = '{50, 50, 50, 2, 50};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_r = '0; in_g = '0; in_b = '0; in_user = '0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_output", got_y.size(), 0);

        clear_q();
        for (int i = 0; i < 8; i++) begin
            send(tv[i]);
            if (i == 0) a0 = last_acc;
        end
        wait_out(8, "stream_count");
        for (int i = 0; i < 8 && i < got_y.size(); i++) begin
            chk($sformatf("stream_y[%0d]", i), got_y[i], tv[i].y);
            chk($sformatf("stream_user[%0d]", i), got_u[i], tv[i].u);
        end
        if (got_c.size() > 0) chk("stream_latency", got_c[0] - a0, 2);

        clear_q();
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send(bp[i]);
            begin
                repeat (5) @(negedge clk);
                chk("stall_in_ready", int'(in_ready), 0);
                chk("stall_out_valid", int'(out_valid), 1);
                chk("stall_out_y", int'(out_y), bp[0].y);
                y_hold = int'(out_y);
                @(negedge clk);
                chk("stall_y_stable", int'(out_y), y_hold);
                chk("stall_user", int'(out_user), bp[0].u);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_out(6, "stall_count");
        for (int i = 0; i < 6 && i < got_y.size(); i++) begin
            chk($sformatf("stall_y[%0d]", i), got_y[i], bp[i].y);
            chk($sformatf("stall_user[%0d]", i), got_u[i], bp[i].u);
        end

        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(bp[i]);
        chk("flight_out_valid", int'(out_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_y", int'(out_y), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_discard", got_y.size(), 0);
        send(tv[3]);
        a0 = last_acc;
        wait_out(1, "midrst_count");
        if (got_y.size() > 0) begin
            chk("midrst_y", got_y[0], 182);
            chk("midrst_user", got_u[0], 3);
            chk("midrst_latency", got_c[0] - a0, 2);
        end

`ifdef COLOR2BW_PROG_COEF_EN
        clear_q();
        cfg(0, 255);
        cfg(1, 255);
        cfg(2, 255);
        cfg(3, 0);
        send('{255, 255, 255, 3, 255});
        send('{10, 10, 10, 1, 30});
        wait_out(2, "coef_count");
        if (got_y.size() > 1) begin
            chk("coef_sat_y", got_y[0], 255);
            chk("coef_y", got_y[1], 30);
            chk("coef_user", got_u[1], 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
